score_draw_ctrl: RTL and testbench
==================================

# score_draw_ctrl

Sequencer that renders a binary score as four decimal digits on the VGA framebuffer by walking the score-glyph ROM (`loadscore`). On `start` it latches the score and screen origin, then converts the score to BCD. It sweeps every glyph pixel of each digit, most significant first, driving the ROM's `id`/`i`/`j` address. It re-times the returned colour into plot strobes with matching x/y.

## Interface
- `GLYPH_H`, default 24: glyph rows per digit; `j` sweeps 0..GLYPH_H-1.
- `DIGIT_PITCH`, default 18: horizontal screen pixels between digit origins.
- `ROM_LATENCY`, default 1: cycles from `rom_*` address to valid `rom_colour`; legal values 1..3.
- `clock` in 1: system clock; all state on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: request a redraw; sampled only in IDLE.
- `score` in 14: binary score; values >9999 saturate to 9999.
- `origin_x` in 8: screen x of the leftmost digit; latched at start.
- `origin_y` in 7: screen y of the top row; latched at start.
- `rom_id` out 5: glyph id (digit value 0..9) to `loadscore.id`.
- `rom_i` out 4: glyph column 0..15 to `loadscore.i`.
- `rom_j` out 8: glyph row 0..GLYPH_H-1 to `loadscore.j`.
- `rom_colour` in 15: `loadscore.outcolour`; only bits [2:0] are used.
- `plot` out 1: framebuffer write strobe.
- `plot_x` out 8: pixel x.
- `plot_y` out 7: pixel y.
- `plot_colour` out 3: pixel colour.
- `busy` out 1: high from the cycle after start acceptance until `done`.
- `done` out 1: one-cycle pulse when the last pixel has been presented.

## Operation
- States: IDLE, CONVERT, DRAW, FLUSH, DONE.
- IDLE: `start`=1 latches the saturated score, `origin_x` and `origin_y`, clears the BCD register, and moves to CONVERT.
- CONVERT: sequential double-dabble, one bit per cycle, MSB first, 14 cycles.
  - Each cycle adds 3 to every BCD nibble ≥5, then shifts.
  - After 14 cycles go to DRAW with digit index d=3 (thousands), row j=0, column i=0.
- DRAW: one address per cycle.
  - `rom_id` = BCD nibble d.
  - Column `i` increments fastest, 0..15. On i=15, i wraps to 0 and j increments. On j=GLYPH_H-1 and i=15, j wraps to 0 and d decrements.
  - After the address for d=0, j=GLYPH_H-1, i=15, go to FLUSH.
  - Leading zeros are drawn; no blanking.
- Pixel pipeline: a ROM_LATENCY-deep shift register carries valid, x and y alongside each address.
  - x = origin_x + (3-d)·DIGIT_PITCH + i.
  - y = origin_y + j.
  - Both are computed modulo 2^8 and 2^7; wrap is not checked.
- Output pixel: `plot` = delayed valid (modified by the transparency feature), `plot_x`/`plot_y` from the pipeline, `plot_colour` = `rom_colour[2:0]`.
- FLUSH: hold ROM_LATENCY cycles so the pipeline drains, then go to DONE.
- DONE: assert `done` for one cycle, return to IDLE.
- `start` while busy is ignored; there is no queueing.
- Reset (any time, including mid-DRAW): state returns to IDLE and the pipeline is cleared. No `done` is emitted for the aborted draw.

## Timing
- Reset values: all outputs 0; `rom_id`, `rom_i`, `rom_j` = 0.
- Start accepted at edge T0. CONVERT occupies T1..T14. The first DRAW address is valid in cycle T15.
- A pixel whose address is presented in cycle N has `plot` asserted in cycle N+ROM_LATENCY.
- DRAW lasts 64·GLYPH_H cycles: 1536 for the default.
- `done` is high in cycle T15 + 64·GLYPH_H + ROM_LATENCY. `busy` drops in the same cycle.
- The earliest next `start` acceptance is the cycle after `done`.
- At most one `plot` per cycle. The plot stream is contiguous while DRAW and FLUSH run.

## Configuration
- `SCORE_TRANSPARENT_EN` defined: pixels with `rom_colour[2:0]`=3'b000 keep their pipeline slot but `plot` is forced 0, so background pixels are not written. Timing and `done` position are unchanged.
- Not defined: every swept pixel asserts `plot`, including black ones, exactly 64·GLYPH_H strobes per draw.

## Test plan
- Score 1234, origin (10,20), transparency off:
  - `rom_id` sequence is 1,2,3,4, each held 384 cycles.
  - 1536 plots occur.
  - First plot is at (10,20); last plot is at (10+54+15, 20+23) = (79,43).
  - `done` fires 1+14+1536+ROM_LATENCY cycles after start.
- Score 12000: saturates; digits drawn are 9,9,9,9. Score 0: digits drawn are 0,0,0,0.
- ROM model returning colour = i[2:0]:
  - Each plot's colour equals the low bits of its own x offset, checking latency alignment.
  - Repeat with ROM_LATENCY=1, 2 and 3.
- `SCORE_TRANSPARENT_EN` with the same ROM model:
  - Columns where i[2:0]=0 produce no plot.
  - Plot count is 1344.
  - `done` cycle is unchanged.
- Reset (`reset`=0) asserted mid-DRAW at digit 2:
  - Outputs return to 0 immediately; no `done` is emitted.
  - A subsequent `start` produces a full correct draw.
- `start` pulsed during CONVERT and DRAW: ignored, with exactly one `done` per accepted start.

Source files
------------

// File: rtl/score_draw_if.sv
// Signal bundle between a score-draw requester, the score glyph ROM and score_draw_ctrl.
// The requester/ROM side uses the master modport; the controller uses the slave modport.
interface score_draw_if;
  logic        start;
  logic [13:0] score;
  logic [7:0]  origin_x;
  logic [6:0]  origin_y;
  logic [4:0]  rom_id;
  logic [3:0]  rom_i;
  logic [7:0]  rom_j;
  logic [14:0] rom_colour;
  logic        plot;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [2:0]  plot_colour;
  logic        busy;
  logic        done;

  modport master (
    output start, score, origin_x, origin_y, rom_colour,
    input  rom_id, rom_i, rom_j, plot, plot_x, plot_y, plot_colour, busy, done
  );

  modport slave (
    input  start, score, origin_x, origin_y, rom_colour,
    output rom_id, rom_i, rom_j, plot, plot_x, plot_y, plot_colour, busy, done
  );
endinterface

// File: rtl/score_draw_ctrl.sv
// Draws a saturated 4-digit decimal score by sweeping the score glyph ROM and emitting plot strobes.
// Optional feature: define SCORE_TRANSPARENT_EN to suppress plots of black (colour 0) glyph pixels.
module score_draw_ctrl #(
  parameter int GLYPH_H     = 24,
  parameter int DIGIT_PITCH = 18,
  parameter int ROM_LATENCY = 1
) (
  input logic         clock,
  input logic         reset,
  score_draw_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CONVERT, DRAW, FLUSH, DONE} state_t;

  state_t      state, state_next;

  logic [13:0] bin;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  bit_cnt;
  logic [7:0]  org_x;
  logic [6:0]  org_y;
  logic [1:0]  dig;
  logic [3:0]  col;
  logic [7:0]  row;
  logic [1:0]  flush_cnt;

  logic        accept;
  logic        draw_last;
  logic [13:0] score_sat;
  logic [3:0]  digit_val;
  logic [7:0]  x_calc;
  logic [6:0]  y_calc;

  logic        valid_pipe [ROM_LATENCY];
  logic [7:0]  x_pipe     [ROM_LATENCY];
  logic [6:0]  y_pipe     [ROM_LATENCY];
  logic        valid_out;
  logic        unused_bits;

  assign score_sat = (bus.score > 14'd9999) ? 14'd9999 : bus.score;
  assign digit_val = bcd[{dig, 2'b00} +: 4];
  assign draw_last = (dig == 2'd0) && (row == 8'(GLYPH_H - 1)) && (col == 4'hF);

  // Digit 3 is the leftmost (thousands) glyph, so its screen offset is zero.
  assign x_calc = org_x + 8'(32'(2'd3 - dig) * DIGIT_PITCH) + {4'd0, col};
  assign y_calc = org_y + row[6:0];

  // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 4; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) begin
        bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        bus.busy = 1'b1;
        if (bit_cnt == 4'd13) begin
          state_next = DRAW;
        end
      end
      DRAW: begin
        bus.busy = 1'b1;
        if (draw_last) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        bus.busy = 1'b1;
        if (flush_cnt == 2'(ROM_LATENCY - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Conversion shift register, sweep counters and latched origin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bin       <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      org_x     <= '0;
      org_y     <= '0;
      dig       <= '0;
      col       <= '0;
      row       <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bin     <= score_sat;
            bcd     <= '0;
            bit_cnt <= '0;
            org_x   <= bus.origin_x;
            org_y   <= bus.origin_y;
            dig     <= 2'd3;
            col     <= '0;
            row     <= '0;
          end
        end
        CONVERT: begin
          bcd     <= {bcd_adj[14:0], bin[13]};
          bin     <= {bin[12:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
        end
        DRAW: begin
          flush_cnt <= '0;
          col       <= col + 4'd1;
          if (col == 4'hF) begin
            if (row == 8'(GLYPH_H - 1)) begin
              row <= '0;
              dig <= dig - 2'd1;
            end else begin
              row <= row + 8'd1;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Coordinates travel alongside the ROM address so they meet the returned colour.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < ROM_LATENCY; k++) begin
        valid_pipe[k] <= 1'b0;
        x_pipe[k]     <= '0;
        y_pipe[k]     <= '0;
      end
    end else begin
      valid_pipe[0] <= (state == DRAW);
      x_pipe[0]     <= x_calc;
      y_pipe[0]     <= y_calc;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        valid_pipe[k] <= valid_pipe[k-1];
        x_pipe[k]     <= x_pipe[k-1];
        y_pipe[k]     <= y_pipe[k-1];
      end
    end
  end

  assign valid_out = valid_pipe[ROM_LATENCY-1];

`ifdef SCORE_TRANSPARENT_EN
  assign bus.plot = valid_out & (|bus.rom_colour[2:0]);
`else
  assign bus.plot = valid_out;
`endif

  assign bus.plot_x      = x_pipe[ROM_LATENCY-1];
  assign bus.plot_y      = y_pipe[ROM_LATENCY-1];
  assign bus.plot_colour = valid_out ? bus.rom_colour[2:0] : 3'd0;

  assign bus.rom_id = {1'b0, digit_val};
  assign bus.rom_i  = col;
  assign bus.rom_j  = row;

  // Upper ROM colour bits fall outside the 3-bit palette; the thousands nibble never overflows.
  assign unused_bits = ^{bus.rom_colour[14:3], bcd_adj[15]};

endmodule

// File: tb/tb_score_draw_ctrl.sv
// Bench for score_draw_ctrl: three instances (ROM latency 1..3) checked against a per-pixel reference model.
module tb_score_draw_ctrl;

  localparam int NINST   = 3;
  localparam int GH      = 24;
  localparam int PITCH   = 18;
  localparam int DIGLEN  = GH * 16;
  localparam int DRAWLEN = 4 * DIGLEN;
`ifdef SCORE_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  typedef struct {
    int score;
    int ox;
    int oy;
    int digits;
    int fx;
    int fy;
    int lx;
    int ly;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] score = '0;
  logic [7:0]  ox = '0;
  logic [6:0]  oy = '0;

  logic [NINST-1:0]       plotV, busyV, doneV;
  logic [NINST-1:0][7:0]  xV, jV;
  logic [NINST-1:0][6:0]  yV;
  logic [NINST-1:0][2:0]  colV;
  logic [NINST-1:0][4:0]  idV;
  logic [NINST-1:0][3:0]  iV;

  int checks = 0;
  int errors = 0;

  int cyc [NINST];
  bit act [NINST];
  int digExp [NINST][4];
  int oxL [NINST];
  int oyL [NINST];
  int plotCnt [NINST];
  int doneCnt [NINST];
  int totalDone [NINST];
  int doneAt [NINST];
  bit doneFlag [NINST];
  int firstX [NINST], firstY [NINST], lastX [NINST], lastY [NINST];
  int digSeen [NINST][4];

  vec_t tbl [7];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NINST; g++) begin : inst
    score_draw_if bus ();
    logic [3:0] ipipe [g+1];

    assign bus.start    = start;
    assign bus.score    = score;
    assign bus.origin_x = ox;
    assign bus.origin_y = oy;

    // Glyph ROM stand-in: colour is the low bits of the column, returned g+1 cycles later.
    always_ff @(posedge clock) begin
      ipipe[0] <= bus.rom_i;
      for (int k = 1; k <= g; k++) begin
        ipipe[k] <= ipipe[k-1];
      end
    end
    assign bus.rom_colour = {11'h2D3, ipipe[g]};

    score_draw_ctrl #(.GLYPH_H(GH), .DIGIT_PITCH(PITCH), .ROM_LATENCY(g + 1)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
    );

    assign plotV[g] = bus.plot;
    assign busyV[g] = bus.busy;
    assign doneV[g] = bus.done;
    assign xV[g]    = bus.plot_x;
    assign yV[g]    = bus.plot_y;
    assign colV[g]  = bus.plot_colour;
    assign idV[g]   = bus.rom_id;
    assign iV[g]    = bus.rom_i;
    assign jV[g]    = bus.rom_j;
  end

  task automatic checkOutput(input string name, input int g, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s inst%0d (latency %0d) at %0t: got %0d expected %0d",
               name, g, g + 1, $time, actual, expected);
    end
  endtask

  task automatic rstCheck(input string tag);
    for (int g = 0; g < NINST; g++) begin
      checkOutput({tag, "_plot"}, g, plotV[g], 0);
      checkOutput({tag, "_busy"}, g, busyV[g], 0);
      checkOutput({tag, "_done"}, g, doneV[g], 0);
      checkOutput({tag, "_x"}, g, xV[g], 0);
      checkOutput({tag, "_y"}, g, yV[g], 0);
      checkOutput({tag, "_colour"}, g, colV[g], 0);
      checkOutput({tag, "_id"}, g, idV[g], 0);
      checkOutput({tag, "_i"}, g, iV[g], 0);
      checkOutput({tag, "_j"}, g, jV[g], 0);
    end
  endtask

  // Reference model: pixel k of a draw is digit k/384, row (k%384)/16, column k%16.
  always @(negedge clock) begin
    int c, k, cdone, lat, s, dIdx, col;
    bit expPlot;
    for (int g = 0; g < NINST; g++) begin
      lat   = g + 1;
      cdone = 15 + DRAWLEN + lat;
      if (!reset) begin
        act[g] = 1'b0;
        checkOutput("rst_plot", g, plotV[g], 0);
        checkOutput("rst_busy", g, busyV[g], 0);
        checkOutput("rst_done", g, doneV[g], 0);
        checkOutput("rst_id", g, idV[g], 0);
        checkOutput("rst_i", g, iV[g], 0);
        checkOutput("rst_j", g, jV[g], 0);
      end else if (act[g]) begin
        c = cyc[g];
        checkOutput("busy", g, busyV[g], int'(c >= 1 && c < cdone));
        checkOutput("done", g, doneV[g], int'(c == cdone));
        if (c >= 15 && c < 15 + DRAWLEN) begin
          k = c - 15;
          checkOutput("rom_id", g, idV[g], digExp[g][k / DIGLEN]);
          checkOutput("rom_i", g, iV[g], k % 16);
          checkOutput("rom_j", g, jV[g], (k / 16) % GH);
          if (k % DIGLEN == 0) digSeen[g][k / DIGLEN] = idV[g];
        end
        expPlot = 1'b0;
        if (c >= 15 + lat && c < 15 + lat + DRAWLEN) begin
          k    = c - 15 - lat;
          dIdx = k / DIGLEN;
          col  = k % 16;
          expPlot = !TRANSP || (col % 8 != 0);
          if (expPlot) begin
            checkOutput("plot_x", g, xV[g], (oxL[g] + dIdx * PITCH + col) % 256);
            checkOutput("plot_y", g, yV[g], (oyL[g] + (k % DIGLEN) / 16) % 128);
            checkOutput("plot_colour", g, colV[g], col % 8);
          end
        end
        checkOutput("plot", g, plotV[g], int'(expPlot));
        if (plotV[g]) begin
          if (plotCnt[g] == 0) begin
            firstX[g] = xV[g];
            firstY[g] = yV[g];
          end
          lastX[g] = xV[g];
          lastY[g] = yV[g];
          plotCnt[g]++;
        end
        if (doneV[g]) begin
          doneCnt[g]++;
          totalDone[g]++;
          doneAt[g]   = c;
          doneFlag[g] = 1'b1;
        end
        if (c == cdone) act[g] = 1'b0;
        else cyc[g] = c + 1;
      end else begin
        checkOutput("idle_plot", g, plotV[g], 0);
        checkOutput("idle_busy", g, busyV[g], 0);
        checkOutput("idle_done", g, doneV[g], 0);
        if (start) begin
          s = (int'(score) > 9999) ? 9999 : int'(score);
          digExp[g][0] = s / 1000;
          digExp[g][1] = (s / 100) % 10;
          digExp[g][2] = (s / 10) % 10;
          digExp[g][3] = s % 10;
          oxL[g]     = int'(ox);
          oyL[g]     = int'(oy);
          act[g]     = 1'b1;
          cyc[g]     = 1;
          plotCnt[g] = 0;
          doneCnt[g] = 0;
          for (int n = 0; n < 4; n++) digSeen[g][n] = -1;
        end
      end
    end
  end

  task automatic applyStimulus(input int sc, input int x, input int y, input bit glitch);
    int n;
    @(posedge clock); #1;
    score = 14'(sc);
    ox    = 8'(x);
    oy    = 7'(y);
    for (int g = 0; g < NINST; g++) doneFlag[g] = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (!(doneFlag[0] && doneFlag[1] && doneFlag[2]) && n < 2000) begin
      @(posedge clock); #1;
      n++;
      start = glitch && (n == 5 || n == 600);
      if (start) score = 14'd1111;
    end
    start = 1'b0;
    if (n >= 2000) begin
      for (int g = 0; g < NINST; g++) checkOutput("done_timeout", g, int'(doneFlag[g]), 1);
    end
    @(posedge clock); #1;
  endtask

  task automatic checkVector(input int idx);
    vec_t v;
    v = tbl[idx];
    for (int g = 0; g < NINST; g++) begin
      checkOutput("first_x", g, firstX[g], TRANSP ? (v.fx + 1) % 256 : v.fx);
      checkOutput("first_y", g, firstY[g], v.fy);
      checkOutput("last_x", g, lastX[g], v.lx);
      checkOutput("last_y", g, lastY[g], v.ly);
      checkOutput("plot_count", g, plotCnt[g], TRANSP ? 1344 : 1536);
      checkOutput("done_cycle", g, doneAt[g], 1 + 14 + 1536 + g + 1);
      checkOutput("done_count", g, doneCnt[g], 1);
      for (int n = 0; n < 4; n++) begin
        checkOutput("digit", g, digSeen[g][n], (v.digits >> (12 - 4 * n)) & 15);
      end
    end
  endtask

  initial begin
    int snap [NINST];
    tbl[0] = '{1234,  10,  20, 'h1234,  10,  20, 79,  43};
    tbl[1] = '{12000,  0,   0, 'h9999,   0,   0, 69,  23};
    tbl[2] = '{0,    200, 120, 'h0000, 200, 120, 13,  15};
    tbl[3] = '{16383, 250, 100, 'h9999, 250, 100, 63, 123};
    tbl[4] = '{507,    0, 104, 'h0507,   0, 104, 69, 127};
    tbl[5] = '{9999,   5,   5, 'h9999,   5,   5, 74,  28};
    tbl[6] = '{2468,  30,  40, 'h2468,  30,  40, 99,  63};
    for (int g = 0; g < NINST; g++) begin
      act[g] = 1'b0;
      totalDone[g] = 0;
    end

    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 rstCheck("rst_init");
    @(posedge clock); #1 reset = 1'b1;

    for (int t = 0; t < 6; t++) begin
      applyStimulus(tbl[t].score, tbl[t].ox, tbl[t].oy, 1'b0);
      checkVector(t);
    end

    $display("[TB] reset during digit 2");
    @(posedge clock); #1;
    score = 14'd1234; ox = 8'd10; oy = 7'd20; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (15 + DIGLEN + 100) @(posedge clock);
    #1 reset = 1'b0;
    #1 rstCheck("rst_mid");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    for (int g = 0; g < NINST; g++) snap[g] = totalDone[g];
    applyStimulus(1234, 10, 20, 1'b0);
    checkVector(0);
    for (int g = 0; g < NINST; g++) checkOutput("abort_done_total", g, totalDone[g] - snap[g], 1);

    $display("[TB] start pulses while busy");
    for (int g = 0; g < NINST; g++) snap[g] = totalDone[g];
    applyStimulus(2468, 30, 40, 1'b1);
    checkVector(6);
    repeat (30) @(posedge clock);
    for (int g = 0; g < NINST; g++) checkOutput("busy_start_done_total", g, totalDone[g] - snap[g], 1);

    $display("[TB] randomized stimulus");
    for (int n = 0; n < 16000; n++) begin
      @(posedge clock); #1;
      start = ($urandom_range(0, 59) == 0);
      score = 14'($urandom);
      ox    = 8'($urandom);
      oy    = 7'($urandom);
      reset = ($urandom_range(0, 4999) != 0);
    end
    @(posedge clock); #1;
    start = 1'b0;
    reset = 1'b1;
    repeat (1600) @(posedge clock);
    #1;
    for (int g = 0; g < NINST; g++) checkOutput("final_busy", g, busyV[g], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
